// File: rtl/io_bus_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | io_bus_sequencer : sequences CPU IO-window accesses onto N_DEV one-hot   |
// |   peripherals with minimum wait states; optional timeout: IO_TIMEOUT_EN  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module io_bus_sequencer #(
  parameter int N_DEV       = 4,
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [9:0]            io_addr,
  input  logic [31:0]           io_wdata,
  output logic [31:0]           io_rdata,
  output logic                  stall,
  output logic [N_DEV-1:0]      dev_sel,
  output logic                  dev_rd,
  output logic                  dev_wr,
  output logic [3:0]            dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [32*N_DEV-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]      dev_ack,
  output logic                  bus_err,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [6:0] N_DEV_W = 7'(N_DEV);
  localparam logic [3:0] WAIT_W  = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic        dir_wr_q, dir_wr_d;
  logic [5:0]  sel_q, sel_d;
  logic [3:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic [31:0] rdata_sel;
  logic        ack_sel;
  logic        accept;
  logic        timeout;

  always_comb begin
    rdata_sel = '0;
    ack_sel   = 1'b0;
    for (int d = 0; d < N_DEV; d++) begin
      if (sel_q == 6'(d)) begin
        rdata_sel = dev_rdata[32*d +: 32];
        ack_sel   = dev_ack[d];
      end
    end
  end

  // Wait counter saturates, so ">= WAIT_STATES" stays true on long accesses.
  assign accept = (state_q == ACCESS) && ack_sel && (wait_q >= WAIT_W);

`ifdef IO_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_q, to_d;

  always_comb begin
    to_d = (state_q == ACCESS) ? to_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end

  assign timeout = (state_q == ACCESS) && (to_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    dir_wr_d = dir_wr_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wait_d   = wait_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: begin
        if (io_read && io_write) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (io_read || io_write) begin
          dir_wr_d = io_write;
          sel_d    = io_addr[9:4];
          addr_d   = io_addr[3:0];
          wdata_d  = io_wdata;
          wait_d   = '0;
          if ({1'b0, io_addr[9:4]} < N_DEV_W) begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (wait_q != 4'hF) wait_d = wait_q + 4'd1;
        if (accept) begin
          state_d = DONE;
          err_d   = 1'b0;
          rdata_d = dir_wr_q ? 32'd0 : rdata_sel;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = dir_wr_q ? 32'd0 : 32'hDEAD_BEEF;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
        if (err_q && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      dir_wr_q <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_wr_q <= dir_wr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them at once.
  for (genvar d = 0; d < N_DEV; d++) begin : g_dev_sel
    assign dev_sel[d] = (state_q == ACCESS) && (sel_q == 6'(d));
  end

  assign stall     = reset_n && (io_read || io_write) && (state_q != DONE);
  assign dev_rd    = (state_q == ACCESS) && !dir_wr_q;
  assign dev_wr    = (state_q == ACCESS) && dir_wr_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign io_rdata  = rdata_q;
  assign bus_err   = (state_q == DONE) && err_q;
  assign err_count = errcnt_q;

endmodule
`default_nettype wire
